mac_sequencer: RTL and testbench

- Control FSM that sequences one multiply-accumulate pass over an operand store built from the memory cells.
- Accepts a start/length command and walks read addresses 0..len-1.
- Drives operand-latch loads, accumulator clear/enable and the final result write.
- Reports busy/done. Sits between the host-side command interface and the MAC datapath (multiplier, adder, accumulator registers).

---
 rtl/mac_sequencer_if.sv | 29 ++
 rtl/mac_sequencer.sv | 126 ++++++++++++
 tb/tb_mac_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_if.sv
// Command/control bundle between the host-side command port, the
// mac_sequencer control FSM and the MAC datapath it steers.
interface mac_sequencer_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  len;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  op_load;
    logic                  acc_clear;
    logic                  acc_en;
    logic                  result_we;

    // Host side: issues commands, observes status and datapath controls.
    modport master (
        output start, len, abort,
        input  busy, done, rd_addr, op_load, acc_clear, acc_en, result_we
    );

    // Sequencer side: consumes commands, drives status and datapath controls.
    modport slave (
        input  start, len, abort,
        output busy, done, rd_addr, op_load, acc_clear, acc_en, result_we
    );
endinterface

// File: rtl/mac_sequencer.sv
// Control FSM for one multiply-accumulate pass over the operand store.
// A start command clears the accumulator, walks read addresses 0..len-1
// loading operand latches, lets the last product drain into the
// accumulator, then writes the result and pulses done. All outputs are
// decoded from registered state or are flops themselves, so nothing on
// the command side reaches the outputs combinationally.
module mac_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic           clk,
    input  logic           rst,
    mac_sequencer_if.slave cmd
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(1 << ADDR_WIDTH);
    localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

    state_t                state;
    state_t                next_state;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LEN_WIDTH-1:0]  len_sat;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  acc_en_q;

    // Requests longer than the store depth are clipped to a full-depth pass.
    assign len_sat = (cmd.len > MAX_LEN) ? MAX_LEN : cmd.len;

    // State register; reset drops any pass in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; abort only matters while a pass is still collecting.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (cmd.start) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                if (cmd.abort) begin
                    next_state = IDLE;
                end else if (remaining == '0) begin
                    next_state = DONE;
                end else begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cmd.abort) begin
                    next_state = IDLE;
                end else if (remaining == ONE) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (cmd.abort) begin
                    next_state = IDLE;
                end else begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Address walk and remaining count; the address holds on the last
    // operand so it never runs past len-1 or wraps on a full-depth pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            rd_addr_q <= '0;
        end else begin
            if (state == IDLE && cmd.start) begin
                remaining <= len_sat;
                rd_addr_q <= '0;
            end else if (state == RUN && !cmd.abort) begin
                remaining <= remaining - ONE;
                if (remaining != ONE) begin
                    rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Accumulate one cycle after each operand load, killed by abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_en_q <= 1'b0;
        end else begin
            acc_en_q <= (state == RUN) && !cmd.abort;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        cmd.busy      = (state != IDLE);
        cmd.acc_clear = (state == CLEAR);
        cmd.op_load   = (state == RUN);
        cmd.done      = (state == DONE);
        cmd.result_we = (state == DONE);
        cmd.acc_en    = acc_en_q;
        cmd.rd_addr   = rd_addr_q;
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed self-checking bench for mac_sequencer. Each pass is started
// at edge 0; outputs are sampled on the falling edge of every cycle and
// compared against the cycle windows worked out by hand for that length.
module tb_mac_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    mac_sequencer_if #(.ADDR_WIDTH(4), .LEN_WIDTH(5)) bus ();

    mac_sequencer #(.ADDR_WIDTH(4), .LEN_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .cmd (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkAllLow(input string tag);
        checkOutput({tag, " busy"},      32'(bus.busy),      0);
        checkOutput({tag, " done"},      32'(bus.done),      0);
        checkOutput({tag, " rd_addr"},   32'(bus.rd_addr),   0);
        checkOutput({tag, " op_load"},   32'(bus.op_load),   0);
        checkOutput({tag, " acc_clear"}, 32'(bus.acc_clear), 0);
        checkOutput({tag, " acc_en"},    32'(bus.acc_en),    0);
        checkOutput({tag, " result_we"}, 32'(bus.result_we), 0);
    endtask

    // Run one pass: start with length l at edge 0, optionally abort at the
    // edge ending cycle abort_at, optionally pulse a second start in cycle
    // restart_at. Expected per-cycle windows come from the effective length;
    // the final op/acc/done totals are hand-computed by the caller.
    task automatic applyStimulus(input string name, input logic [4:0] l,
                                 input int abort_at, input bit abort_with_start,
                                 input int restart_at, input logic [4:0] restart_len,
                                 input int exp_ops, input int exp_accs,
                                 input int exp_dones);
        int eff;
        int done_c;
        int last;
        int ops;
        int accs;
        int dones;
        bit exp_op;
        eff    = (l > 5'd16) ? 16 : int'(l);
        done_c = (eff == 0) ? 2 : eff + 3;
        last   = (abort_at >= 1 && abort_at < done_c) ? abort_at : done_c;
        ops    = 0;
        accs   = 0;
        dones  = 0;

        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = l;
        bus.abort = abort_with_start;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.len   = '0;

        for (int k = 1; k <= done_c + 2; k++) begin
            exp_op = (k <= last) && (k >= 2) && (k <= eff + 1);
            checkOutput($sformatf("%s c%0d busy", name, k), 32'(bus.busy), 32'(k <= last));
            checkOutput($sformatf("%s c%0d acc_clear", name, k), 32'(bus.acc_clear),
                        32'((k <= last) && (k == 1)));
            checkOutput($sformatf("%s c%0d op_load", name, k), 32'(bus.op_load), 32'(exp_op));
            checkOutput($sformatf("%s c%0d acc_en", name, k), 32'(bus.acc_en),
                        32'((k <= last) && (k >= 3) && (k <= eff + 2)));
            checkOutput($sformatf("%s c%0d done", name, k), 32'(bus.done),
                        32'((k <= last) && (k == done_c)));
            checkOutput($sformatf("%s c%0d result_we", name, k), 32'(bus.result_we),
                        32'((k <= last) && (k == done_c)));
            if (exp_op) begin
                checkOutput($sformatf("%s c%0d rd_addr", name, k), 32'(bus.rd_addr), 32'(k - 2));
            end
            checkOutput($sformatf("%s c%0d clear&acc", name, k),
                        32'(bus.acc_clear & bus.acc_en), 0);
            checkOutput($sformatf("%s c%0d load&we", name, k),
                        32'(bus.op_load & bus.result_we), 0);
            ops   += int'(bus.op_load);
            accs  += int'(bus.acc_en);
            dones += int'(bus.done);
            bus.abort = (k == abort_at);
            bus.start = (k == restart_at);
            bus.len   = (k == restart_at) ? restart_len : 5'd0;
            @(posedge clk);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.len   = '0;

        checkOutput({name, " op_load count"}, 32'(ops),   32'(exp_ops));
        checkOutput({name, " acc_en count"},  32'(accs),  32'(exp_accs));
        checkOutput({name, " done count"},    32'(dones), 32'(exp_dones));
    endtask

    // Directed sequence: reset, nominal, boundaries, busy start, aborts, reset mid-pass.
    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.len   = '0;
        bus.abort = 1'b0;
        #12;
        checkAllLow("reset");
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("nominal5", 5'd5,  -1, 1'b0, -1, 5'd0, 5, 5, 1);
        applyStimulus("zero",     5'd0,  -1, 1'b0, -1, 5'd0, 0, 0, 1);
        applyStimulus("full16",   5'd16, -1, 1'b0, -1, 5'd0, 16, 16, 1);
        applyStimulus("sat31",    5'd31, -1, 1'b0, -1, 5'd0, 16, 16, 1);
        applyStimulus("busystart", 5'd4, -1, 1'b0,  3, 5'd9, 4, 4, 1);
        applyStimulus("abort6",   5'd6,   4, 1'b0, -1, 5'd0, 3, 2, 0);
        applyStimulus("abortdone", 5'd2,  5, 1'b0, -1, 5'd0, 2, 2, 1);
        applyStimulus("startabort", 5'd3, -1, 1'b1, -1, 5'd0, 3, 3, 1);

        // Asynchronous reset in the middle of cycle 5 of a len=8 pass.
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 5'd8;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = '0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rstmid busy before", 32'(bus.busy), 1);
        checkOutput("rstmid op_load before", 32'(bus.op_load), 1);
        #1;
        rst = 1'b1;
        #1;
        checkAllLow("rstmid async");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rstmid after c%0d done", k), 32'(bus.done), 0);
            checkOutput($sformatf("rstmid after c%0d busy", k), 32'(bus.busy), 0);
        end
        applyStimulus("afterrst2", 5'd2, -1, 1'b0, -1, 5'd0, 2, 2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
